// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one single-cycle ALU between two
// requesters. Operands are registered and driven to the ALU; the ALU result is
// captured and returned on a per-requester valid/ready response channel.
// ALU_MUL holds its operands for MUL_CYCLES cycles so the multiplier can be
// constrained as a multicycle path. MUL_CYCLES must lie in 1..15.

`ifndef ALU_AND
`define ALU_AND 3'b000
`endif
`ifndef ALU_OR
`define ALU_OR  3'b001
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b010
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b011
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'b100
`endif
`ifndef ALU_SLL
`define ALU_SLL 3'b101
`endif
`ifndef ALU_MUL
`define ALU_MUL 3'b110
`endif

module alu_arbiter #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    output logic        resp0_valid_o,
    input  logic        resp0_ready_i,
    output logic [31:0] resp0_data_o,
    output logic        resp1_valid_o,
    input  logic        resp1_ready_i,
    output logic [31:0] resp1_data_o,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i,
    output logic        busy_o
);

    // Extra EXEC cycles spent on a multiply before its result is sampled.
    localparam logic [3:0] MUL_HOLD = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        gnt_q, gnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] data2_q, data2_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        gnt_sel;
    logic        accept;
    logic [2:0]  sel_op;
    logic [31:0] sel_data1;
    logic [31:0] sel_data2;
    logic        sel_resp_ready;

    // On contention the prio bit decides; otherwise the only valid requester wins.
    assign gnt_sel = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;

    // Ready is gated by reset so nothing is offered while the block is held in reset.
    assign accept       = rst_n_i & (state_q == IDLE) & (req0_valid_i | req1_valid_i);
    assign req0_ready_o = accept & ~gnt_sel;
    assign req1_ready_o = accept & gnt_sel;

    assign sel_op         = gnt_sel ? req1_op_i    : req0_op_i;
    assign sel_data1      = gnt_sel ? req1_data1_i : req0_data1_i;
    assign sel_data2      = gnt_sel ? req1_data2_i : req0_data2_i;
    assign sel_resp_ready = gnt_q   ? resp1_ready_i : resp0_ready_i;

    // Next-state and datapath register update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        op_d     = op_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = sel_op;
                    data1_d = sel_data1;
                    data2_d = sel_data2;
                    gnt_d   = gnt_sel;
                    cnt_d   = (sel_op == `ALU_MUL) ? MUL_HOLD : 4'd0;
                    prio_d  = ~gnt_sel;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d = alu_data_i;
                    state_d  = RESP;
                end
            end
            RESP: begin
                // No accept in this cycle: ready is only offered from IDLE.
                if (sel_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset asserts asynchronously and drops any in-flight op.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            op_q     <= 3'd0;
            data1_q  <= 32'd0;
            data2_q  <= 32'd0;
            result_q <= 32'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // ALU inputs come straight from registers, so they are glitch-free for the whole hold.
    assign alu_data1_o = data1_q;
    assign alu_data2_o = data2_q;
    assign alu_ctrl_o  = op_q;

    assign resp0_valid_o = (state_q == RESP) & ~gnt_q;
    assign resp1_valid_o = (state_q == RESP) & gnt_q;
    assign resp0_data_o  = result_q;
    assign resp1_data_o  = result_q;

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU closes the loop, a scoreboard
// queue holds expected responses pushed at accept time and popped when the
// response handshake is seen.

`ifndef ALU_AND
`define ALU_AND 3'b000
`endif
`ifndef ALU_OR
`define ALU_OR  3'b001
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b010
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b011
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'b100
`endif
`ifndef ALU_SLL
`define ALU_SLL 3'b101
`endif
`ifndef ALU_MUL
`define ALU_MUL 3'b110
`endif

module tb_alu_arbiter;

    localparam int MUL_CYCLES = 3;
    localparam logic [31:0] UNDEF_RESULT = 32'hBADC_0DE5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [2:0]  req_op [2];
    logic [31:0] req_d1 [2];
    logic [31:0] req_d2 [2];
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b11;
    logic [31:0] resp_data [2];
    logic [31:0] alu_d1, alu_d2, alu_res;
    logic [2:0]  alu_ctrl;
    logic        busy;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t     sb[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       cyc = 0;
    int       rise[2];
    bit [1:0] prev_v = 2'b00;

    alu_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req0_valid_i (req_valid[0]),
        .req0_ready_o (req_ready[0]),
        .req0_op_i    (req_op[0]),
        .req0_data1_i (req_d1[0]),
        .req0_data2_i (req_d2[0]),
        .req1_valid_i (req_valid[1]),
        .req1_ready_o (req_ready[1]),
        .req1_op_i    (req_op[1]),
        .req1_data1_i (req_d1[1]),
        .req1_data2_i (req_d2[1]),
        .resp0_valid_o(resp_valid[0]),
        .resp0_ready_i(resp_ready[0]),
        .resp0_data_o (resp_data[0]),
        .resp1_valid_o(resp_valid[1]),
        .resp1_ready_i(resp_ready[1]),
        .resp1_data_o (resp_data[1]),
        .alu_data1_o  (alu_d1),
        .alu_data2_o  (alu_d2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_data_i   (alu_res),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-cycle ALU; unknown codes return a recognisable constant.
    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            `ALU_AND: return a & b;
            `ALU_OR:  return a | b;
            `ALU_ADD: return a + b;
            `ALU_SUB: return a - b;
            `ALU_XOR: return a ^ b;
            `ALU_SLL: return a << b[4:0];
            `ALU_MUL: return a * b;
            default:  return UNDEF_RESULT;
        endcase
    endfunction

    assign alu_res = alu_f(alu_ctrl, alu_d1, alu_d2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flag(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // One clock: sample on the falling edge, track response rises, score handshakes.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (resp_valid[k] && !prev_v[k]) rise[k] = cyc;
            prev_v[k] = resp_valid[k];
            if (resp_valid[k] && resp_ready[k]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_resp%0d", k), 32'(resp_valid[k]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 32'(k), 32'(e.id));
                    chk("resp_data", resp_data[k], e.data);
                    chk("resp_latency", 32'(rise[k] - e.acc - 1), 32'(e.lat));
                    $display("txn: resp%0d data=%h latency=%0d", k, resp_data[k], rise[k] - e.acc - 1);
                end
            end
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] d, input int lat);
        exp_t e;
        e.id = id; e.data = d; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    // Offer one request and hold it until accepted (bounded).
    task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input int lat, input bit expect_it);
        bit done = 1'b0;
        req_op[id] = op; req_d1[id] = a; req_d2[id] = b; req_valid[id] = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            if (req_ready[id]) begin
                if (expect_it) push_exp(id, exp_d, lat);
                $display("txn: req%0d op=%b a=%h b=%h accepted", id, op, a, b);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_valid[id] = 1'b0;
        if (!done) flag("accept_timeout");
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() > 0; n++) begin
            step();
            @(posedge clk); #1;
        end
        if (sb.size() > 0) flag("drain_timeout");
    endtask

    logic [2:0]  t_op [8];
    logic [31:0] t_a [8];
    logic [31:0] t_b [8];
    logic [31:0] t_ex [8];

    initial begin
        int cnt_g [2];
        int n_acc;
        int g;
        int idx;
        for (int k = 0; k < 2; k++) begin
            req_op[k] = 3'd0; req_d1[k] = 32'd0; req_d2[k] = 32'd0; rise[k] = 0;
        end

        // ---- reset with req0 ADD 5,7 pending ----
        req_op[0] = `ALU_ADD; req_d1[0] = 32'd5; req_d2[0] = 32'd7; req_valid[0] = 1'b1;
        step();
        chk("rst_ready0", 32'(req_ready[0]), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_alu_d1", alu_d1, 32'd0);
        chk("rst_alu_d2", alu_d2, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready0_first_cycle", 32'(req_ready[0]), 32'd1);
        chk("ready1_first_cycle", 32'(req_ready[1]), 32'd0);
        if (req_ready[0]) push_exp(0, 32'd12, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_resp1_quiet", 32'(resp_valid[1]), 32'd0);
            @(posedge clk); #1;
        end
        chk("t1_drained", 32'(sb.size()), 32'd0);
        sb.delete();

        // ---- fresh reset so prio starts at 0, then 4 contended pairs ----
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        t_op[0] = `ALU_SUB; t_a[0] = 32'd10;      t_b[0] = 32'd3;      t_ex[0] = 32'd7;
        t_op[1] = `ALU_XOR; t_a[1] = 32'h0000F0F0; t_b[1] = 32'h00000FF0; t_ex[1] = 32'h0000FF00;
        for (int i = 2; i < 8; i++) begin
            case ($urandom_range(0, 5))
                0:       t_op[i] = `ALU_AND;
                1:       t_op[i] = `ALU_OR;
                2:       t_op[i] = `ALU_ADD;
                3:       t_op[i] = `ALU_SUB;
                4:       t_op[i] = `ALU_XOR;
                default: t_op[i] = `ALU_SLL;
            endcase
            t_a[i] = $urandom; t_b[i] = $urandom;
            t_ex[i] = alu_f(t_op[i], t_a[i], t_b[i]);
        end
        cnt_g[0] = 0; cnt_g[1] = 0; n_acc = 0;
        for (int k = 0; k < 2; k++) begin
            req_op[k] = t_op[k]; req_d1[k] = t_a[k]; req_d2[k] = t_b[k];
        end
        req_valid = 2'b11;
        for (int n = 0; n < 200 && n_acc < 8; n++) begin
            step();
            g = -1;
            if (req_ready[0]) g = 0;
            if (req_ready[1]) g = 1;
            if (g >= 0) begin
                chk("single_ready", 32'(req_ready[0] & req_ready[1]), 32'd0);
                chk("rr_grant", 32'(g), 32'(n_acc % 2));
                idx = 2 * cnt_g[g] + g;
                push_exp(g, t_ex[idx], 1);
                $display("txn: req%0d op=%b a=%h b=%h accepted", g, t_op[idx], t_a[idx], t_b[idx]);
                cnt_g[g]++;
                n_acc++;
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                idx = 2 * cnt_g[g] + g;
                if (idx < 8) begin
                    req_op[g] = t_op[idx]; req_d1[g] = t_a[idx]; req_d2[g] = t_b[idx];
                end else begin
                    req_valid[g] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
        if (n_acc < 8) flag("rr_accept_timeout");
        drain();

        // ---- multiply on req1 held for MUL_CYCLES ----
        issue(1, `ALU_MUL, 32'h1234, 32'h10, 32'h00012340, MUL_CYCLES, 1'b1);
        for (int i = 0; i < MUL_CYCLES; i++) begin
            step();
            chk("mul_ctrl_hold", 32'(alu_ctrl), 32'(`ALU_MUL));
            chk("mul_d1_hold", alu_d1, 32'h1234);
            chk("mul_no_resp_yet", 32'(resp_valid[1]), 32'd0);
            @(posedge clk); #1;
        end
        drain();

        // ---- responder stall on req0 SLL 1,4 while req1 waits ----
        resp_ready[0] = 1'b0;
        issue(0, `ALU_SLL, 32'd1, 32'd4, 32'd16, 1, 1'b1);
        req_op[1] = `ALU_ADD; req_d1[1] = 32'd2; req_d2[1] = 32'd3; req_valid[1] = 1'b1;
        step();
        chk("stall_exec_ready1", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid0", 32'(resp_valid[0]), 32'd1);
            chk("stall_data0", resp_data[0], 32'd16);
            chk("stall_ready1", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        step();
        chk("hs_cycle_ready1", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        step();
        chk("after_hs_ready1", 32'(req_ready[1]), 32'd1);
        if (req_ready[1]) push_exp(1, 32'd5, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        // ---- reset during the second EXEC cycle of a multiply ----
        issue(0, `ALU_MUL, 32'd3, 32'd4, 32'd12, MUL_CYCLES, 1'b0);
        step();
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("abort_alu_d1", alu_d1, 32'd0);
        chk("abort_alu_d2", alu_d2, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end

        // ---- undefined op code passes through as a 1-cycle op ----
        issue(0, 3'b111, 32'd1, 32'd2, UNDEF_RESULT, 1, 1'b1);
        drain();
        step();
        chk("undef_back_idle", 32'(busy), 32'd0);
        chk("undef_ctrl_kept", 32'(alu_ctrl), 32'd7);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
